// File: rtl/bus_arbiter2_pkg.sv
// Shared definitions for the two-requester bus arbiter: FSM states and
// requester indices.
package bus_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LSU   = 1;

  function automatic state_t own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/bus_arbiter2_mux2.sv
// Two-input, WIDTH-bit multiplexer feeding the shared memory address.
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin arbiter giving a fetch and a load/store requester bounded
// bursts on one shared memory port.
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [1:0]       last,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic             mem_ready,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_valid
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  state_t        state, state_nxt;
  logic          prio, prio_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sel_nxt;
  logic          owner;
  logic          own_req;
  logic          oth_req;
  logic          own_last;
  logic          beat;
  logic          release_own;

  assign owner    = (state == OWN1);
  assign own_req  = req[owner];
  assign oth_req  = req[~owner];
  assign own_last = last[owner];

  assign gnt       = {state == OWN1, state == OWN0};
  assign mem_valid = (state != IDLE) && own_req;
  assign beat      = mem_valid && mem_ready;

  // A dropped request releases immediately; otherwise only a completing beat can.
  assign release_own = !own_req ||
                       (beat && (own_last || (cnt + 1'b1 == MAX_CNT)));

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = cnt;
    if (state == IDLE) begin
      cnt_nxt = '0;
      if (req == 2'b11)
        state_nxt = own_state(prio);
      else if (req[REQ_LSU])
        state_nxt = OWN1;
      else if (req[REQ_FETCH])
        state_nxt = OWN0;
    end else if (release_own) begin
      prio_nxt = ~owner;
      cnt_nxt  = '0;
      if (oth_req)
        state_nxt = own_state(~owner);
      else if (own_req)
        state_nxt = own_state(owner);
      else
        state_nxt = IDLE;
    end else if (beat) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // sel follows the owner and keeps its last value while idle.
  always_comb begin
    sel_nxt = sel;
    if (state_nxt == OWN1)
      sel_nxt = 1'b1;
    else if (state_nxt == OWN0)
      sel_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
    end
  end

  mux2 #(.WIDTH(WIDTH)) u_addr_mux (
    .a0 (addr0),
    .a1 (addr1),
    .s  (sel),
    .y  (mem_addr)
  );

endmodule
